// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Issues dcache read/write requests for EX/MEM loads and stores. It stalls the front of the
// pipeline while a request is outstanding. It owns the MEM/WB pipeline register that feeds
// writeback and the forwarding unit.
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   *_exmem             EX/MEM latch fields (valid, ALU result/address, store data, npc,
//                       rt/rd, RegDst, RegWr, MemRead/MemWrite, wsrc, halt)
//   dhit, dmemload      dcache completion and load data
//   dmemREN/WEN/addr/store  dcache request
//   mem_stall           freeze IF..EX/MEM while a request is pending
//   *_memwb, wsel_memwb, wdat_memwb  MEM/WB register
//   halt, mem_err       sticky halt and watchdog error
//   stall_cycles        saturating count of stalled cycles
module mem_stage #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_exmem,
  input  logic [WORD_W-1:0] ALUOut_exmem,
  input  logic [WORD_W-1:0] store_exmem,
  input  logic [WORD_W-1:0] npc_exmem,
  input  logic [REG_W-1:0]  rt_exmem,
  input  logic [REG_W-1:0]  rd_exmem,
  input  logic [1:0]        RegDst_exmem,
  input  logic              RegWr_exmem,
  input  logic              MemRead_exmem,
  input  logic              MemWrite_exmem,
  input  logic [1:0]        wsrc_exmem,
  input  logic              halt_exmem,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              valid_memwb,
  output logic              RegWr_memwb,
  output logic [1:0]        RegDst_memwb,
  output logic [REG_W-1:0]  rt_memwb,
  output logic [REG_W-1:0]  rd_memwb,
  output logic [REG_W-1:0]  wsel_memwb,
  output logic [WORD_W-1:0] wdat_memwb,
  output logic              halt,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               mem_err_q, mem_err_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               valid_q, valid_d;
  logic               regwr_q, regwr_d;
  logic [1:0]         regdst_q, regdst_d;
  logic [REG_W-1:0]   rt_q, rt_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [REG_W-1:0]   wsel_q, wsel_d;
  logic [WORD_W-1:0]  wdat_q, wdat_d;
  logic               memop;
  logic               stall;

  // Requests are gated by RST so a reset mid-WAIT drops REN/WEN immediately.
  always_comb begin
    memop   = valid_exmem & (MemRead_exmem | MemWrite_exmem) & ~halt_q & ~RST;
    dmemREN = memop & MemRead_exmem & ~mem_err_q;
    // Read wins if both MemRead and MemWrite are set.
    dmemWEN = memop & MemWrite_exmem & ~MemRead_exmem & ~mem_err_q;
    stall   = memop & ~dhit & ~mem_err_q;
  end

  // Request handshake FSM with the wait watchdog.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      StIdle: begin
        if (stall) begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        if (dhit) begin
          state_d = StIdle;
        end else begin
          wait_d = WaitW'(wait_q + 1'b1);
          if (wait_d == WaitW'(MAX_WAIT)) begin
            mem_err_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // MEM/WB register: advance when not stalled, otherwise insert a bubble and hold data.
  always_comb begin
    valid_d  = 1'b0;
    regwr_d  = 1'b0;
    regdst_d = regdst_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    wsel_d   = wsel_q;
    wdat_d   = wdat_q;
    halt_d   = halt_q;
    if (!stall) begin
      valid_d  = valid_exmem;
      regwr_d  = RegWr_exmem & valid_exmem;
      regdst_d = RegDst_exmem;
      rt_d     = rt_exmem;
      rd_d     = rd_exmem;
      case (RegDst_exmem)
        2'b01:   wsel_d = rd_exmem;
        2'b10:   wsel_d = REG_W'(31);
        default: wsel_d = rt_exmem;
      endcase
      case (wsrc_exmem)
        2'b01:   wdat_d = dmemload;
        2'b10:   wdat_d = npc_exmem;
        default: wdat_d = ALUOut_exmem;
      endcase
      halt_d = halt_q | (halt_exmem & valid_exmem);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      halt_q    <= 1'b0;
      stall_q   <= '0;
      valid_q   <= 1'b0;
      regwr_q   <= 1'b0;
      regdst_q  <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wsel_q    <= '0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      halt_q    <= halt_d;
      stall_q   <= stall_d;
      valid_q   <= valid_d;
      regwr_q   <= regwr_d;
      regdst_q  <= regdst_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      wsel_q    <= wsel_d;
      wdat_q    <= wdat_d;
    end
  end

  assign mem_stall    = stall;
  assign dmemaddr     = ALUOut_exmem;
  assign dmemstore    = store_exmem;
  assign valid_memwb  = valid_q;
  assign RegWr_memwb  = regwr_q;
  assign RegDst_memwb = regdst_q;
  assign rt_memwb     = rt_q;
  assign rd_memwb     = rd_q;
  assign wsel_memwb   = wsel_q;
  assign wdat_memwb   = wdat_q;
  assign halt         = halt_q;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned MAX_WAIT = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              valid_exmem;
  logic [WORD_W-1:0] ALUOut_exmem, store_exmem, npc_exmem, dmemload;
  logic [REG_W-1:0]  rt_exmem, rd_exmem;
  logic [1:0]        RegDst_exmem, wsrc_exmem;
  logic              RegWr_exmem, MemRead_exmem, MemWrite_exmem, halt_exmem, dhit;
  logic              dmemREN, dmemWEN, mem_stall, valid_memwb, RegWr_memwb, halt, mem_err;
  logic [WORD_W-1:0] dmemaddr, dmemstore, wdat_memwb;
  logic [1:0]        RegDst_memwb;
  logic [REG_W-1:0]  rt_memwb, rd_memwb, wsel_memwb;
  logic [CNT_W-1:0]  stall_cycles;

  int checks = 0;
  int failures = 0;

  mem_stage #(
    .WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK(CLK), .RST(RST), .valid_exmem(valid_exmem), .ALUOut_exmem(ALUOut_exmem),
    .store_exmem(store_exmem), .npc_exmem(npc_exmem), .rt_exmem(rt_exmem),
    .rd_exmem(rd_exmem), .RegDst_exmem(RegDst_exmem), .RegWr_exmem(RegWr_exmem),
    .MemRead_exmem(MemRead_exmem), .MemWrite_exmem(MemWrite_exmem),
    .wsrc_exmem(wsrc_exmem), .halt_exmem(halt_exmem), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .valid_memwb(valid_memwb), .RegWr_memwb(RegWr_memwb),
    .RegDst_memwb(RegDst_memwb), .rt_memwb(rt_memwb), .rd_memwb(rd_memwb),
    .wsel_memwb(wsel_memwb), .wdat_memwb(wdat_memwb), .halt(halt), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    valid_exmem = 0; ALUOut_exmem = '0; store_exmem = '0; npc_exmem = '0;
    rt_exmem = '0; rd_exmem = '0; RegDst_exmem = '0; RegWr_exmem = 0;
    MemRead_exmem = 0; MemWrite_exmem = 0; wsrc_exmem = '0; halt_exmem = 0;
    dhit = 0; dmemload = '0;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    #12;
    chk("rst_valid", valid_memwb, 0);
    chk("rst_regwr", RegWr_memwb, 0);
    chk("rst_wdat", wdat_memwb, 0);
    chk("rst_wsel", wsel_memwb, 0);
    chk("rst_halt", halt, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_cnt", stall_cycles, 0);
    RST = 1'b0;
    tick();

    // ALU op writing rd.
    valid_exmem = 1; RegDst_exmem = 2'b01; rd_exmem = 7; rt_exmem = 3;
    ALUOut_exmem = 32'h1234; wsrc_exmem = 2'b00; RegWr_exmem = 1;
    #1;
    chk("alu_stall", mem_stall, 0);
    chk("alu_ren", dmemREN, 0);
    tick();
    chk("alu_wsel", wsel_memwb, 7);
    chk("alu_wdat", wdat_memwb, 32'h1234);
    chk("alu_regwr", RegWr_memwb, 1);
    chk("alu_valid", valid_memwb, 1);
    chk("alu_rt", rt_memwb, 3);
    chk("alu_regdst", RegDst_memwb, 1);

    // Load, dhit three cycles after the request.
    RegDst_exmem = 2'b00; rt_exmem = 9; ALUOut_exmem = 32'h40; MemRead_exmem = 1;
    wsrc_exmem = 2'b01; dmemload = 32'hDEADBEEF; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_stall", mem_stall, 1);
      chk("ld_ren", dmemREN, 1);
      chk("ld_addr", dmemaddr, 32'h40);
      tick();
      chk("ld_bubble_regwr", RegWr_memwb, 0);
      chk("ld_bubble_valid", valid_memwb, 0);
      chk("ld_hold_wdat", wdat_memwb, 32'h1234);
    end
    dhit = 1;
    #1;
    chk("ld_hit_stall", mem_stall, 0);
    tick();
    chk("ld_wdat", wdat_memwb, 32'hDEADBEEF);
    chk("ld_wsel", wsel_memwb, 9);
    chk("ld_regwr", RegWr_memwb, 1);
    chk("ld_cnt", stall_cycles, 3);

    // Store with same-cycle hit.
    MemRead_exmem = 0; MemWrite_exmem = 1; ALUOut_exmem = 32'h80; store_exmem = 32'hCAFE;
    RegWr_exmem = 0; wsrc_exmem = 2'b00; dhit = 1;
    #1;
    chk("st_wen", dmemWEN, 1);
    chk("st_ren", dmemREN, 0);
    chk("st_data", dmemstore, 32'hCAFE);
    chk("st_stall", mem_stall, 0);
    tick();
    chk("st_regwr", RegWr_memwb, 0);
    chk("st_valid", valid_memwb, 1);
    chk("st_cnt", stall_cycles, 3);

    // jal link.
    MemWrite_exmem = 0; dhit = 0; RegWr_exmem = 1; RegDst_exmem = 2'b10;
    wsrc_exmem = 2'b10; npc_exmem = 32'h104; ALUOut_exmem = 32'h5;
    #1;
    chk("jal_wen", dmemWEN, 0);
    tick();
    chk("jal_wsel", wsel_memwb, 31);
    chk("jal_wdat", wdat_memwb, 32'h104);

    // RegDst=11 and wsrc=11 fall back to rt / ALU.
    RegDst_exmem = 2'b11; rt_exmem = 4; wsrc_exmem = 2'b11; ALUOut_exmem = 32'h77;
    tick();
    chk("dflt_wsel", wsel_memwb, 4);
    chk("dflt_wdat", wdat_memwb, 32'h77);

    // Load that never hits: watchdog after MAX_WAIT WAIT cycles.
    RegDst_exmem = 2'b00; rt_exmem = 10; wsrc_exmem = 2'b01; ALUOut_exmem = 32'h44;
    MemRead_exmem = 1; dmemload = 32'h55AA; dhit = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_stall", mem_stall, 1);
      tick();
    end
    #1;
    chk("to_err", mem_err, 1);
    chk("to_stall_drop", mem_stall, 0);
    chk("to_ren_drop", dmemREN, 0);
    chk("to_cnt_sat", stall_cycles, 7);
    tick();
    chk("to_adv_valid", valid_memwb, 1);
    chk("to_adv_wdat", wdat_memwb, 32'h55AA);
    chk("to_adv_wsel", wsel_memwb, 10);
    RST = 1;
    #1;
    chk("to_rst_err", mem_err, 0);
    chk("to_rst_cnt", stall_cycles, 0);
    RST = 0;
    tick();

    // Reset mid-WAIT, then a halt.
    #1;
    chk("rw_ren", dmemREN, 1);
    tick();
    chk("rw_stall", mem_stall, 1);
    RST = 1;
    #1;
    chk("rw_ren_drop", dmemREN, 0);
    chk("rw_stall_drop", mem_stall, 0);
    chk("rw_valid", valid_memwb, 0);
    chk("rw_wdat", wdat_memwb, 0);
    chk("rw_wsel", wsel_memwb, 0);
    MemRead_exmem = 0; halt_exmem = 1; valid_exmem = 1; RegWr_exmem = 0;
    RST = 0;
    #1;
    chk("h_pre", halt, 0);
    tick();
    chk("h_set", halt, 1);
    halt_exmem = 0; MemRead_exmem = 1; dhit = 0;
    #1;
    chk("h_ren_gated", dmemREN, 0);
    chk("h_stall_gated", mem_stall, 0);
    tick();
    chk("h_sticky", halt, 1);
    tick();
    chk("h_sticky2", halt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage of the 5-stage MIPS core.
- Consumes the EX/MEM latch fields and runs data-memory requests against the dcache with an IDLE/WAIT handshake FSM.
- Asserts a stall while a request is pending.
- Owns the MEM/WB pipeline register. Its RegWr/RegDst/rt/rd/wdat outputs feed both writeback and the forwarding unit's MEM/WB inputs.

Parameters:
- WORD_W, 32, datapath word width.
- REG_W, 5, register index width.
- CNT_W, 16, width of the stall-cycle performance counter.
- MAX_WAIT, 255, WAIT-state cycles before the mem_err watchdog fires.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- valid_exmem  in  1  EX/MEM holds a live instruction.
- ALUOut_exmem  in  WORD_W  ALU result; also the memory address.
- store_exmem  in  WORD_W  store data (already forwarded).
- npc_exmem  in  WORD_W  PC+4, used for jal link.
- rt_exmem, rd_exmem  in  REG_W each  destination candidates.
- RegDst_exmem  in  2  00=rt, 01=rd, 10=$31.
- RegWr_exmem  in  1  register write enable.
- MemRead_exmem, MemWrite_exmem  in  1 each  load / store.
- wsrc_exmem  in  2  00=ALU, 01=load data, 10=npc.
- halt_exmem  in  1  halt instruction.
- dhit  in  1  dcache request complete.
- dmemload  in  WORD_W  load data, valid when dhit.
- dmemREN, dmemWEN  out  1 each  dcache read / write request.
- dmemaddr  out  WORD_W  = ALUOut_exmem.
- dmemstore  out  WORD_W  = store_exmem.
- mem_stall  out  1  freeze IF..EX/MEM latches.
- valid_memwb  out  1  MEM/WB holds a live instruction.
- RegWr_memwb  out  1  registered write enable.
- RegDst_memwb  out  2  registered RegDst.
- rt_memwb, rd_memwb  out  REG_W each  registered destination candidates.
- wsel_memwb  out  REG_W  resolved destination register.
- wdat_memwb  out  WORD_W  writeback data.
- halt  out  1  sticky halt.
- mem_err  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous, RST=1): FSM→IDLE; every MEM/WB output, halt, mem_err, stall_cycles and the wait counter→0.
- memop = valid_exmem & (MemRead_exmem | MemWrite_exmem). Both bits set is illegal; read takes priority.
- dmemREN = memop & MemRead_exmem & ~mem_err. dmemWEN = memop & MemWrite_exmem & ~MemRead_exmem & ~mem_err. Both are combinational and held asserted until dhit.
- mem_stall = memop & ~dhit & ~mem_err. This is combinational, so a hit in the request cycle gives zero stall (one-cycle memory).
- FSM, IDLE: if memop & ~dhit, go to WAIT and clear the wait counter. Otherwise stay in IDLE.
- FSM, WAIT: on dhit, go to IDLE. Otherwise increment the wait counter; when it reaches MAX_WAIT, set mem_err and go to IDLE.
- With mem_err set: requests and stall are suppressed. MEM/WB keeps loading: loads write dmemload as sampled, stores are dropped.
- MEM/WB register update at every rising edge, when mem_stall=0 (advance):
  - valid_memwb ← valid_exmem.
  - RegWr_memwb ← RegWr_exmem & valid_exmem.
  - RegDst_memwb, rt_memwb, rd_memwb ← the EX/MEM fields.
  - wsel_memwb ← rt / rd / 31 per RegDst_exmem; RegDst=11 is treated as rt.
  - wdat_memwb ← ALUOut / dmemload / npc per wsrc_exmem; wsrc=11 is treated as ALU.
  - halt ← halt | (halt_exmem & valid_exmem).
- MEM/WB register update when mem_stall=1 (bubble): valid_memwb=0, RegWr_memwb=0. Data fields hold their previous values, so no spurious forwards can occur.
- halt is sticky until RST. After halt is set, this block issues no further requests: memop is gated with ~halt.
- stall_cycles increments on every cycle with mem_stall=1 and saturates at all-ones.
- Reset mid-WAIT: immediately returns to IDLE and drops REN/WEN. No write side effect is guaranteed.

Test Plan:
- ALU op, RegDst=01, rd=7, ALUOut=0x1234, wsrc=00, no memop → next edge: wsel=7, wdat=0x1234, RegWr=1, mem_stall never 1.
- Load at addr 0x40, dhit asserted 3 cycles after request, dmemload=0xDEADBEEF → mem_stall=1 for exactly 3 cycles, 3 bubbles with RegWr_memwb=0, then wdat=0xDEADBEEF, stall_cycles=3.
- Store addr 0x80, data 0xCAFE, dhit in the same cycle → dmemWEN=1 for 1 cycle, dmemstore=0xCAFE, no stall, RegWr_memwb=0.
- jal, RegDst=10, wsrc=10, npc=0x104 → wsel=31, wdat=0x104.
- Load with dhit never asserted, MAX_WAIT=4 → mem_err=1 after 4 WAIT cycles, mem_stall drops, pipeline advances; reset clears mem_err.
- Assert RST during WAIT, then halt_exmem with valid=1 → all outputs 0 asynchronously; after release, halt=1 one edge after halt enters and stays 1.
